// File: rtl/pifo_client.sv
// pifo_client: initiator-side adapter pacing insert/remove strobes to a PIFO core with a 2-entry dequeue buffer
module pifo_client #(
  parameter int RANK_WIDTH = 10,
  parameter int META_WIDTH = 20,
  parameter int CAPACITY = 160,
  parameter int INSERT_GAP = 1,
  parameter int REMOVE_GAP = 2,
  localparam int OCC_W = $clog2(CAPACITY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [RANK_WIDTH-1:0] enq_rank,
  input  logic [META_WIDTH-1:0] enq_meta,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic                  pifo_insert,
  output logic                  pifo_remove,
  output logic [RANK_WIDTH-1:0] pifo_rank_in,
  output logic [META_WIDTH-1:0] pifo_meta_in,
  input  logic [RANK_WIDTH-1:0] pifo_rank_out,
  input  logic [META_WIDTH-1:0] pifo_meta_out,
  input  logic                  pifo_valid_out,
  input  logic                  pifo_busy,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  err_underflow
);
  localparam int GW = $clog2((INSERT_GAP > REMOVE_GAP ? INSERT_GAP : REMOVE_GAP) + 2);
  localparam int EW = RANK_WIDTH + META_WIDTH;
  typedef enum logic [1:0] {IDLE, INS_HOLD, REM_HOLD} state_e;
  state_e state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic last_rem_q, last_rem_d;
  logic err_q;
  logic [EW-1:0] buf_q [2];
  logic [EW-1:0] buf_d [2];
  logic [1:0] bcnt_q, bcnt_d, bcnt_after;
  logic pop, ins_ok, rem_ok;
  assign pop = deq_valid && deq_ready;
  assign bcnt_after = bcnt_q - {1'b0, pop};
  assign ins_ok = rst && state_q == IDLE && !pifo_busy && occ_q < OCC_W'(CAPACITY);
  assign rem_ok = rst && state_q == IDLE && pifo_valid_out && occ_q != '0 && bcnt_after < 2'd2;
  assign enq_ready = ins_ok && !(rem_ok && !last_rem_q);
  assign pifo_insert = enq_valid && enq_ready;
  assign pifo_remove = rem_ok && !pifo_insert;
  assign pifo_rank_in = enq_rank;
  assign pifo_meta_in = enq_meta;
  assign deq_valid = bcnt_q != 2'd0;
  assign deq_rank = buf_q[0][EW-1:META_WIDTH];
  assign deq_meta = buf_q[0][META_WIDTH-1:0];
  assign occupancy = occ_q;
  assign err_underflow = err_q;
  // Gap countdown, occupancy tracking and grant history
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    occ_d = occ_q;
    last_rem_d = last_rem_q;
    if (state_q != IDLE) begin
      cnt_d = cnt_q - GW'(1);
      state_d = cnt_q <= GW'(1) ? IDLE : state_q;
    end
    if (pifo_insert) begin
      occ_d = occ_q + 1'b1;
      last_rem_d = 1'b0;
      cnt_d = GW'(INSERT_GAP);
      state_d = INSERT_GAP == 0 ? IDLE : INS_HOLD;
    end else if (pifo_remove) begin
      occ_d = occ_q - 1'b1;
      last_rem_d = 1'b1;
      cnt_d = GW'(REMOVE_GAP);
      state_d = REMOVE_GAP == 0 ? IDLE : REM_HOLD;
    end
  end
  // Output buffer: pop shifts the tail forward, push lands behind whatever remains
  always_comb begin
    buf_d = buf_q;
    bcnt_d = bcnt_after + {1'b0, pifo_remove};
    if (pop) buf_d[0] = buf_q[1];
    if (pifo_remove) buf_d[bcnt_after[0]] = {pifo_rank_out, pifo_meta_out};
  end
  // Control state with synchronous active-low reset; reset discards buffered items
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      occ_q <= '0;
      last_rem_q <= 1'b0;
      bcnt_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      last_rem_q <= last_rem_d;
      bcnt_q <= bcnt_d;
      err_q <= err_q | (pifo_valid_out && occ_q == '0);
    end
  end
  // Buffer payload needs no reset; validity comes from bcnt_q
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_pifo_client.sv
// tb_pifo_client: directed vector table plus hand-written sequences for pifo_client
module tb_pifo_client;
  localparam int RW = 10, MW = 20, CAP = 4, OW = $clog2(CAP + 1);
  logic clk = 1'b0, rst = 1'b0;
  logic enq_valid = 1'b0, enq_ready, deq_valid, deq_ready = 1'b0;
  logic [RW-1:0] enq_rank = '0, deq_rank, pifo_rank_in, pifo_rank_out = '0;
  logic [MW-1:0] enq_meta = '0, deq_meta, pifo_meta_in, pifo_meta_out = '0;
  logic pifo_insert, pifo_remove, pifo_valid_out = 1'b0, pifo_busy = 1'b0, err_underflow;
  logic [OW-1:0] occupancy;
  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  pifo_client #(.RANK_WIDTH(RW), .META_WIDTH(MW), .CAPACITY(CAP), .INSERT_GAP(1), .REMOVE_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rank(enq_rank), .enq_meta(enq_meta),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
    .pifo_insert(pifo_insert), .pifo_remove(pifo_remove),
    .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_valid_out(pifo_valid_out), .pifo_busy(pifo_busy),
    .occupancy(occupancy), .err_underflow(err_underflow)
  );

  typedef struct {
    logic rst, ev;
    logic [RW-1:0] rank;
    logic [MW-1:0] meta;
    logic busy, pv;
    logic [RW-1:0] prank;
    logic [MW-1:0] pmeta;
    logic dr;
    logic er, ins, rem, dv;
    logic [RW-1:0] drank;
    logic [MW-1:0] dmeta;
    logic [OW-1:0] occ;
  } vec_t;

  vec_t tv [26];

  function automatic vec_t mk(input logic r, ev, input int rank, meta, input logic busy, pv,
                              input int prank, pmeta, input logic dr, er, ins, rem, dv,
                              input int drank, dmeta, occ);
    vec_t v;
    v.rst = r; v.ev = ev; v.rank = RW'(rank); v.meta = MW'(meta); v.busy = busy; v.pv = pv;
    v.prank = RW'(prank); v.pmeta = MW'(pmeta); v.dr = dr;
    v.er = er; v.ins = ins; v.rem = rem; v.dv = dv;
    v.drank = RW'(drank); v.dmeta = MW'(dmeta); v.occ = OW'(occ);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int cnt, g;
    logic seen;
    //          rst ev rank meta  bsy pv prank pmeta  dr | er ins rem dv drank dmeta occ
    tv[0]  = mk(0, 1, 7, 'h11, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tv[1]  = mk(0, 1, 7, 'h11, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tv[2]  = mk(0, 1, 7, 'h11, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    tv[3]  = mk(1, 1, 7, 'h11, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 0,     0);
    tv[4]  = mk(1, 1, 3, 'h22, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     1);
    tv[5]  = mk(1, 1, 3, 'h22, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 0,     1);
    tv[6]  = mk(1, 1, 5, 'h33, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     2);
    tv[7]  = mk(1, 1, 5, 'h33, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 0,     2);
    tv[8]  = mk(1, 0, 0, 0,    0, 1, 3, 'h22,  1, 0, 0, 0, 0, 0, 0,     3);
    tv[9]  = mk(1, 0, 0, 0,    0, 1, 3, 'h22,  1, 0, 0, 1, 0, 0, 0,     3);
    tv[10] = mk(1, 0, 0, 0,    0, 1, 5, 'h33,  1, 0, 0, 0, 1, 3, 'h22,  2);
    tv[11] = mk(1, 0, 0, 0,    0, 1, 5, 'h33,  1, 0, 0, 0, 0, 0, 0,     2);
    tv[12] = mk(1, 0, 0, 0,    0, 1, 5, 'h33,  1, 1, 0, 1, 0, 0, 0,     2);
    tv[13] = mk(1, 0, 0, 0,    0, 1, 7, 'h11,  1, 0, 0, 0, 1, 5, 'h33,  1);
    tv[14] = mk(1, 0, 0, 0,    0, 1, 7, 'h11,  1, 0, 0, 0, 0, 0, 0,     1);
    tv[15] = mk(1, 0, 0, 0,    0, 1, 7, 'h11,  1, 1, 0, 1, 0, 0, 0,     1);
    tv[16] = mk(1, 0, 0, 0,    0, 0, 0, 0,     1, 0, 0, 0, 1, 7, 'h11,  0);
    tv[17] = mk(1, 0, 0, 0,    0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     0);
    for (int i = 18; i < 23; i++)
      tv[i] = mk(1, 1, 9, 'h99, 1, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0,     0);
    tv[23] = mk(1, 1, 9, 'h99, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 0,     0);
    tv[24] = mk(1, 0, 0, 0,    0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0,     1);
    tv[25] = mk(1, 0, 0, 0,    0, 0, 0, 0,     1, 1, 0, 0, 0, 0, 0,     1);

    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      rst = tv[i].rst; enq_valid = tv[i].ev; enq_rank = tv[i].rank; enq_meta = tv[i].meta;
      pifo_busy = tv[i].busy; pifo_valid_out = tv[i].pv; pifo_rank_out = tv[i].prank;
      pifo_meta_out = tv[i].pmeta; deq_ready = tv[i].dr;
      #1;
      chk($sformatf("v%0d enq_ready", i), enq_ready, tv[i].er);
      chk($sformatf("v%0d pifo_insert", i), pifo_insert, tv[i].ins);
      chk($sformatf("v%0d pifo_remove", i), pifo_remove, tv[i].rem);
      chk($sformatf("v%0d deq_valid", i), deq_valid, tv[i].dv);
      chk($sformatf("v%0d occupancy", i), occupancy, tv[i].occ);
      chk($sformatf("v%0d err_underflow", i), err_underflow, 0);
      chk($sformatf("v%0d pifo_rank_in", i), pifo_rank_in, tv[i].rank);
      chk($sformatf("v%0d pifo_meta_in", i), pifo_meta_in, tv[i].meta);
      if (tv[i].dv) begin
        chk($sformatf("v%0d deq_rank", i), deq_rank, tv[i].drank);
        chk($sformatf("v%0d deq_meta", i), deq_meta, tv[i].dmeta);
      end
      @(negedge clk);
    end

    // fill to capacity
    enq_valid = 1; pifo_valid_out = 0; deq_ready = 1; cnt = 0;
    for (int k = 0; k < 12 && occupancy != OW'(CAP); k++) begin
      enq_rank = RW'(20 + k);
      #1;
      if (pifo_insert) cnt++;
      @(negedge clk);
    end
    chk("fill_inserts", cnt, 3);
    chk("fill_occ", occupancy, CAP);
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_enq_ready", enq_ready, 0);
      @(negedge clk);
    end
    enq_valid = 0; pifo_valid_out = 1; pifo_rank_out = 11; pifo_meta_out = 'hbb;
    #1 chk("full_remove", pifo_remove, 1);
    @(negedge clk);
    pifo_valid_out = 0;
    #1 chk("rem_occ", occupancy, 3);
    chk("gap1_enq_ready", enq_ready, 0);
    @(negedge clk);
    #1 chk("gap2_enq_ready", enq_ready, 0);
    @(negedge clk);
    #1 chk("after_gap_enq_ready", enq_ready, 1);
    enq_valid = 1;
    #1 chk("refill_insert", pifo_insert, 1);
    @(negedge clk);
    enq_valid = 0;
    #1 chk("refill_occ", occupancy, CAP);

    // output backpressure
    deq_ready = 0; pifo_valid_out = 1; cnt = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (pifo_remove) cnt++;
      @(negedge clk);
    end
    chk("bp_removes", cnt, 2);
    #1 chk("bp_occ", occupancy, 2);
    chk("bp_deq_valid", deq_valid, 1);
    chk("bp_deq_rank", deq_rank, 11);
    deq_ready = 1; seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      #1;
      if (pifo_remove) seen = 1;
      else @(negedge clk);
    end
    chk("resume_remove", seen, 1);

    // reset during remove hold with buffered items
    @(negedge clk);
    rst = 0; pifo_valid_out = 0; deq_ready = 0; enq_valid = 0;
    @(negedge clk);
    rst = 1;
    #1 chk("rst_deq_valid", deq_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_idle_enq_ready", enq_ready, 1);

    // alternating grants
    enq_valid = 1; deq_ready = 1;
    for (int k = 0; k < 10 && occupancy != OW'(2); k++) begin
      #1;
      @(negedge clk);
    end
    chk("alt_pre_occ", occupancy, 2);
    pifo_valid_out = 1; pifo_rank_out = 1; g = 0;
    for (int k = 0; k < 40 && g < 6; k++) begin
      #1;
      chk("one_strobe", pifo_insert & pifo_remove, 0);
      if (pifo_insert | pifo_remove) begin
        chk($sformatf("grant%0d_is_remove", g), pifo_remove, (g % 2 == 0));
        g++;
      end
      @(negedge clk);
    end
    chk("grants_seen", g, 6);

    // underflow detection
    rst = 0; enq_valid = 0; pifo_valid_out = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1; pifo_valid_out = 1;
    #1 chk("uf_no_remove", pifo_remove, 0);
    chk("uf_err_before", err_underflow, 0);
    @(negedge clk);
    #1 chk("uf_err_set", err_underflow, 1);
    chk("uf_no_remove2", pifo_remove, 0);
    pifo_valid_out = 0;
    @(negedge clk);
    #1 chk("uf_err_sticky", err_underflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
